host_specific_top_tx_to_host: RTL and testbench
===============================================

HOST_SPECIFIC_TOP_TX_TO_HOST -- requirements
Module: host_specific_top_tx_to_host

Interface
REQ-001 SHALL provide the following parameters, one per line: name, default, meaning.
- KEY_BYTE, 8'hA5, XOR decrypt key applied to payload bytes.
- TIMEOUT, 255, maximum idle cycles between chunks inside one packet.

REQ-002 SHALL provide the following ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-high.
- encoded_input, input, 144, two SECDED codewords carrying one 16-byte chunk.
- encoded_valid, input, 1, chunk present.
- encoded_ready, output, 1, block accepts a chunk this cycle.
- encrypt_decrypt_passthrough, input, 1, 1 = decrypt payload; 0 = pass through.
- output_data, output, 1024, assembled packet; byte n at [8n+7:8n].
- packet_valid, output, 1, output_data holds a complete packet.
- host_ack, input, 1, host consumes the packet.
- corrected, output, 1, one-cycle pulse: a single-bit error was corrected in the accepted chunk.
- error, output, 1, one-cycle pulse: packet aborted.
- done, output, 1, one-cycle pulse: packet delivered and acknowledged.

Function
REQ-003 Codeword 0 SHALL be encoded_input[71:0]; codeword 1 SHALL be [143:72].
REQ-004 Codeword layout:
- bit 0 = overall even parity over all 72 bits.
- Bits 1..71 = Hamming positions 1..71.
- Check bits at positions 1, 2, 4, 8, 16, 32, 64.
- Data bits 0..63 at the remaining positions in ascending order.
REQ-005 Syndrome SHALL be the 7-bit XOR of the indices of all set bits in positions 1..71.
REQ-006 Decode outcomes, per codeword:
- syndrome 0 and parity OK: clean.
- syndrome 0 and parity bad: bit-0 error, data unaffected, counts as corrected.
- syndrome 1..71 and parity bad: flip that position, counts as corrected.
- syndrome nonzero and parity OK, or syndrome >71: uncorrectable.
REQ-007 Codeword 0 data bit k SHALL map to chunk byte k/8, bit k%8; codeword 1 SHALL map likewise to bytes 8..15.
REQ-008 Chunk c SHALL occupy packet bytes 16c..16c+15 (c = 0..7).
REQ-009 Packet byte 0 = opcode and byte 1 = total length L in bytes, header included; legal L is 2..128.
REQ-010 Chunks expected SHALL be ceil(L/16), taken from chunk 0.
REQ-011 encrypt_decrypt_passthrough SHALL be sampled at chunk 0 and held for the packet; when 1, bytes 2..L-1 are XORed with KEY_BYTE; bytes 0 and 1 are never modified.
REQ-012 Bytes at index >= L SHALL read 0 in output_data.
REQ-013 States SHALL be IDLE, COLLECT, DELIVER.
REQ-014 encoded_ready SHALL be 1 in IDLE and COLLECT and 0 in DELIVER.
REQ-015 A chunk SHALL be accepted on the edge where encoded_valid && encoded_ready, then decoded and written to the buffer on that same edge.
REQ-016 IDLE transitions on accepting chunk 0:
- Buffer cleared, then chunk 0 written.
- L illegal or uncorrectable word -> error pulse, stay IDLE.
- L <= 16 -> DELIVER.
- Otherwise -> COLLECT.
REQ-017 COLLECT transitions:
- Each accepted chunk increments the chunk index.
- Uncorrectable word -> error pulse, buffer discarded, IDLE.
- Final chunk -> DELIVER.
REQ-018 The COLLECT idle counter SHALL reset on every accepted chunk; reaching TIMEOUT cycles -> error pulse, IDLE.
REQ-019 In DELIVER, packet_valid SHALL be 1 and output_data SHALL be stable until host_ack; host_ack -> done pulse next cycle, IDLE, packet_valid 0.
REQ-020 packet_valid SHALL rise 1 cycle after the final chunk edge.
REQ-021 host_ack outside DELIVER SHALL be ignored.
REQ-022 corrected SHALL pulse the cycle after an accepted chunk with any corrected word, including the chunk that causes an error.
REQ-023 error and done SHALL never assert in the same cycle.

Reset
REQ-024 reset SHALL force IDLE, clear the buffer, chunk index and timeout counter, and drive all of the following to 0:
- output_data
- packet_valid
- corrected
- error
- done
REQ-025 encoded_ready SHALL be 1 from the first cycle after reset.
REQ-026 reset mid-COLLECT or mid-DELIVER SHALL discard the packet with no done or error pulse.

Verification
REQ-027 Bench SHALL cover these scenarios (stimulus -> required response):
- Yaw response, clean: bytes 03,04,34,12, passthrough 0 -> packet_valid 1 cycle later, output_data[31:0] = 32'h12340403, upper bits 0; host_ack -> done pulse.
- Decrypt: same packet, payload sent as 91,B7, passthrough 1 -> output_data[31:0] = 32'h12340403.
- Three-chunk packet, L = 40, with a single bit flipped at codeword 1 position 37 -> corrected pulse, data correct, bytes 40..127 = 0.
- Double-bit error (positions 3 and 5) in chunk 1 of an L = 32 packet -> error pulse, no packet_valid, next packet decodes normally.
- Chunk 0 with L = 1 or L = 200 -> error pulse, state IDLE; in COLLECT with no chunk for 255 cycles -> error pulse.
- DELIVER held 20 cycles without host_ack -> encoded_ready 0, output_data stable; reset asserted mid-COLLECT -> all outputs 0, no done pulse.

Source files
------------

// File: rtl/host_specific_top_tx_to_host.sv
// Reassembles SECDED-protected 16-byte chunks into a host packet of up to 128 bytes.
// The payload is optionally XOR-decrypted. The packet is held until the host acknowledges it.
module host_specific_top_tx_to_host #(
    parameter logic [7:0]  KEY_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [143:0]  encoded_input,
    input  logic          encoded_valid,
    output logic          encoded_ready,
    input  logic          encrypt_decrypt_passthrough,
    output logic [1023:0] output_data,
    output logic          packet_valid,
    input  logic          host_ack,
    output logic          corrected,
    output logic          error,
    output logic          done
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDeliver} state_e;

    typedef struct packed {
        logic        bad;
        logic        corr;
        logic [63:0] data;
    } dec_t;

    // Position 0 is overall parity; data fills the non-power-of-two positions in order.
    function automatic dec_t secded_decode(input logic [71:0] cw);
        dec_t        res;
        logic [6:0]  syn;
        logic [71:0] fixed;
        int unsigned k;
        syn = '0;
        for (int unsigned p = 1; p < 72; p++) begin
            if (cw[p]) syn = syn ^ 7'(p);
        end
        fixed    = cw;
        res.bad  = 1'b0;
        res.corr = 1'b0;
        if (syn == 7'd0) begin
            res.corr = ^cw;
        end else if ((^cw) && (syn <= 7'd71)) begin
            fixed[syn] = ~fixed[syn];
            res.corr   = 1'b1;
        end else begin
            res.bad = 1'b1;
        end
        res.data = '0;
        k = 0;
        for (int unsigned p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                res.data[k[5:0]] = fixed[p];
                k++;
            end
        end
        return res;
    endfunction

    state_e          state_q, state_d;
    logic [1023:0]   buf_q;
    logic [2:0]      idx_q;
    logic [7:0]      len_q;
    logic            decrypt_q;
    logic [CntW-1:0] cnt_q;
    logic            corr_q, err_q, done_q;

    dec_t         dec0, dec1;
    logic [127:0] chunk_raw, chunk_proc;
    logic         chunk_bad, chunk_corr;
    logic [7:0]   hdr_len, cur_len, chunk_cnt, gidx;
    logic         len_legal, cur_dec, in_idle, accept;
    logic [2:0]   cur_idx, last_idx;
    logic         err_ev, done_ev;

    // Decode, then place each byte by its packet index: header untouched, tail beyond L zeroed.
    always_comb begin
        dec0       = secded_decode(encoded_input[71:0]);
        dec1       = secded_decode(encoded_input[143:72]);
        chunk_raw  = {dec1.data, dec0.data};
        chunk_bad  = dec0.bad | dec1.bad;
        chunk_corr = dec0.corr | dec1.corr;
        hdr_len    = chunk_raw[15:8];
        len_legal  = (hdr_len >= 8'd2) && (hdr_len <= 8'd128);
        in_idle    = (state_q == StIdle);
        cur_len    = in_idle ? hdr_len : len_q;
        cur_dec    = in_idle ? encrypt_decrypt_passthrough : decrypt_q;
        cur_idx    = in_idle ? 3'd0 : idx_q;
        chunk_cnt  = (cur_len + 8'd15) >> 4;
        last_idx   = 3'(chunk_cnt - 8'd1);
        accept     = encoded_valid && encoded_ready;
        chunk_proc = '0;
        gidx       = '0;
        for (int b = 0; b < 16; b++) begin
            gidx = {1'b0, cur_idx, 4'(b)};
            if (gidx >= cur_len) begin
                chunk_proc[8*b +: 8] = 8'h00;
            end else if (cur_dec && (gidx >= 8'd2)) begin
                chunk_proc[8*b +: 8] = chunk_raw[8*b +: 8] ^ KEY_BYTE;
            end else begin
                chunk_proc[8*b +: 8] = chunk_raw[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_ev  = 1'b0;
        done_ev = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (chunk_bad || !len_legal) begin
                        err_ev = 1'b1;
                    end else if (hdr_len <= 8'd16) begin
                        state_d = StDeliver;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (accept) begin
                    if (chunk_bad) begin
                        err_ev  = 1'b1;
                        state_d = StIdle;
                    end else if (idx_q == last_idx) begin
                        state_d = StDeliver;
                    end
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_ev  = 1'b1;
                    state_d = StIdle;
                end
            end
            StDeliver: begin
                if (host_ack) begin
                    done_ev = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        encoded_ready = (state_q != StDeliver);
        packet_valid  = (state_q == StDeliver);
        output_data   = buf_q;
        corrected     = corr_q;
        error         = err_q;
        done          = done_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q     <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            decrypt_q <= 1'b0;
            cnt_q     <= '0;
            corr_q    <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            corr_q <= accept && chunk_corr;
            err_q  <= err_ev;
            done_q <= done_ev;
            if (err_ev) begin
                buf_q <= '0;
                idx_q <= '0;
            end else if (accept) begin
                if (in_idle) begin
                    buf_q     <= {896'd0, chunk_proc};
                    len_q     <= hdr_len;
                    decrypt_q <= encrypt_decrypt_passthrough;
                    idx_q     <= 3'd1;
                end else begin
                    buf_q[{idx_q, 7'd0} +: 128] <= chunk_proc;
                    idx_q                       <= idx_q + 3'd1;
                end
            end
            // Idle-gap counter only runs while waiting for the next chunk of a packet.
            if ((state_q == StCollect) && !accept && (state_d == StCollect)) begin
                cnt_q <= cnt_q + CntW'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_host_specific_top_tx_to_host.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor pops and compares them.
module tb_host_specific_top_tx_to_host;

    localparam int KPKT  = 0;
    localparam int KERR  = 1;
    localparam int KCORR = 2;
    localparam int KDONE = 3;

    typedef struct {
        int            kind;
        logic [1023:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic          clk;
    logic          reset;
    logic [143:0]  encoded_input;
    logic          encoded_valid;
    logic          encoded_ready;
    logic          encrypt_decrypt_passthrough;
    logic [1023:0] output_data;
    logic          packet_valid;
    logic          host_ack;
    logic          corrected;
    logic          error;
    logic          done;

    host_specific_top_tx_to_host #(
        .KEY_BYTE(8'hA5),
        .TIMEOUT (255)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .encoded_input              (encoded_input),
        .encoded_valid              (encoded_valid),
        .encoded_ready              (encoded_ready),
        .encrypt_decrypt_passthrough(encrypt_decrypt_passthrough),
        .output_data                (output_data),
        .packet_valid               (packet_valid),
        .host_ack                   (host_ack),
        .corrected                  (corrected),
        .error                      (error),
        .done                       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] enc64(input logic [63:0] d);
        logic [71:0] cw;
        logic [6:0]  s;
        int          k;
        cw = '0;
        s  = '0;
        k  = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int p = 1; p < 72; p++) begin
            if (cw[p]) s = s ^ 7'(p);
        end
        for (int i = 0; i < 7; i++) cw[1 << i] = s[i];
        cw[0] = ^cw[71:1];
        return cw;
    endfunction

    function automatic logic [143:0] mk_chunk(input logic [1023:0] pkt, input int c);
        logic [127:0] ch;
        ch = pkt[128*c +: 128];
        return {enc64(ch[127:64]), enc64(ch[63:0])};
    endfunction

    task automatic push(input int kind, input logic [1023:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic observe(input int kind);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d, required none", kind);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event_order: got kind %0d, required kind %0d", kind, e.kind);
            end else if ((kind == KPKT) && (output_data !== e.data)) begin
                errors++;
                $display("FAIL packet_data: got %h, required %h (low 256 bits)",
                         output_data[255:0], e.data[255:0]);
            end
        end
    endtask

    // Monitor
    initial begin
        logic pv_prev;
        pv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv_prev = 1'b0;
            end else begin
                if (corrected) observe(KCORR);
                if (error) observe(KERR);
                if (packet_valid && !pv_prev) observe(KPKT);
                if (done) observe(KDONE);
                if (error && done) begin
                    checks++;
                    errors++;
                    $display("FAIL error_done_overlap: got both, required at most one");
                end
                pv_prev = packet_valid;
            end
        end
    end

    task automatic send_chunk(input logic [143:0] cw, input logic dec);
        int n;
        n = 0;
        @(negedge clk);
        while (!encoded_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!encoded_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: got ready 0, required 1 within 50 cycles");
        end
        encoded_input               = cw;
        encrypt_decrypt_passthrough = dec;
        encoded_valid               = 1'b1;
        @(negedge clk);
        encoded_valid = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        host_ack = 1'b1;
        @(negedge clk);
        host_ack = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < n) begin
            @(posedge clk);
            i++;
        end
        @(posedge clk);
        chk("queue_drain", exp_q.size(), 0);
    endtask

    task automatic yaw_packet();
        logic [1023:0] p;
        p = '0;
        p[31:0] = 32'h12340403;
        push(KPKT, p);
        send_chunk(mk_chunk(p, 0), 1'b0);
        push(KDONE, '0);
        ack();
        wait_drain(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] src, expd;
        logic [143:0]  cw;
        logic [7:0]    bad_lens[2];
        int            ready_bad, data_bad;

        reset = 1'b1;
        encoded_input = '0;
        encoded_valid = 1'b0;
        encrypt_decrypt_passthrough = 1'b0;
        host_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", encoded_ready, 1);
        chk("reset_valid", packet_valid, 0);
        chk("reset_data_zero", (output_data == '0), 1);
        chk("reset_pulses", {corrected, error, done}, 0);

        // host_ack outside DELIVER must not produce done
        ack();
        wait_drain(5);

        // Clean yaw response, latency check
        src = '0;
        src[31:0] = 32'h12340403;
        push(KPKT, src);
        send_chunk(mk_chunk(src, 0), 1'b0);
        chk("yaw_latency", packet_valid, 1);
        chk("yaw_upper_zero", (output_data[1023:32] == '0), 1);
        push(KDONE, '0);
        ack();
        wait_drain(10);
        chk("after_done_ready", encoded_ready, 1);

        // Decrypt: 91^A5=34, B7^A5=12
        src = '0;
        src[31:0] = 32'hB7910403;
        expd = '0;
        expd[31:0] = 32'h12340403;
        push(KPKT, expd);
        send_chunk(mk_chunk(src, 0), 1'b1);
        push(KDONE, '0);
        ack();
        wait_drain(10);

        // L=40 over three chunks, single-bit flip in chunk 1 codeword 1 position 37
        src = '0;
        src[7:0] = 8'h07;
        src[15:8] = 8'd40;
        for (int i = 2; i < 48; i++) src[8*i +: 8] = (i < 40) ? 8'(i * 7 + 3) : 8'hEE;
        expd = src;
        for (int i = 40; i < 48; i++) expd[8*i +: 8] = 8'h00;
        push(KCORR, '0);
        push(KPKT, expd);
        send_chunk(mk_chunk(src, 0), 1'b0);
        cw = mk_chunk(src, 1);
        cw[72 + 37] = ~cw[72 + 37];
        send_chunk(cw, 1'b0);
        send_chunk(mk_chunk(src, 2), 1'b0);
        chk("l40_valid", packet_valid, 1);
        push(KDONE, '0);
        ack();
        wait_drain(10);

        // Double-bit error in chunk 1 of L=32
        src = '0;
        src[7:0] = 8'h09;
        src[15:8] = 8'd32;
        for (int i = 2; i < 32; i++) src[8*i +: 8] = 8'(i);
        push(KERR, '0);
        send_chunk(mk_chunk(src, 0), 1'b0);
        cw = mk_chunk(src, 1);
        cw[3] = ~cw[3];
        cw[5] = ~cw[5];
        send_chunk(cw, 1'b0);
        wait_drain(10);
        chk("dbl_no_valid", packet_valid, 0);
        yaw_packet();

        // Illegal lengths
        bad_lens[0] = 8'd1;
        bad_lens[1] = 8'd200;
        for (int j = 0; j < 2; j++) begin
            src = '0;
            src[7:0] = 8'h05;
            src[15:8] = bad_lens[j];
            push(KERR, '0);
            send_chunk(mk_chunk(src, 0), 1'b0);
            wait_drain(10);
            chk("badlen_idle_ready", encoded_ready, 1);
            chk("badlen_no_valid", packet_valid, 0);
        end

        // Timeout in COLLECT: error after 255 idle cycles
        src = '0;
        src[7:0] = 8'h0A;
        src[15:8] = 8'd32;
        push(KERR, '0);
        send_chunk(mk_chunk(src, 0), 1'b0);
        repeat (250) @(posedge clk);
        #1;
        chk("timeout_not_early", exp_q.size(), 1);
        wait_drain(20);
        yaw_packet();

        // DELIVER held 20 cycles with a chunk offered
        src = '0;
        src[31:0] = 32'h12340403;
        push(KPKT, src);
        send_chunk(mk_chunk(src, 0), 1'b0);
        expd = '0;
        expd[31:0] = 32'h55AA0403;
        ready_bad = 0;
        data_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            encoded_input = mk_chunk(expd, 0);
            encoded_valid = 1'b1;
            if (encoded_ready !== 1'b0) ready_bad++;
            if (output_data !== src) data_bad++;
        end
        @(negedge clk);
        encoded_valid = 1'b0;
        chk("hold_ready_low", ready_bad, 0);
        chk("hold_data_stable", data_bad, 0);
        push(KDONE, '0);
        ack();
        wait_drain(10);

        // Reset mid-COLLECT
        src = '0;
        src[7:0] = 8'h0B;
        src[15:8] = 8'd32;
        send_chunk(mk_chunk(src, 0), 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", packet_valid, 0);
        chk("midrst_data_zero", (output_data == '0), 1);
        chk("midrst_pulses", {corrected, error, done}, 0);
        chk("midrst_ready", encoded_ready, 1);
        repeat (5) @(negedge clk);
        yaw_packet();

        wait_drain(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
